// File: rtl/exe_mem_skid_reg.sv
// Two-entry skid register carrying EXE results into the MEM stage (main entry drives outputs, skid entry absorbs one stall).
// Latency: a beat accepted while empty appears on the outputs one cycle later.
// Backpressure: in_ready drops only when both entries are full; it depends on registered state only, never on out_ready.
module exe_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              WB_en_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic [DATA_W-1:0] ALU_Result_in,
    input  logic [DATA_W-1:0] val_Rm_in,
    input  logic [REG_W-1:0]  Dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              WB_en,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic [DATA_W-1:0] ALU_result,
    output logic [DATA_W-1:0] val_Rm,
    output logic [REG_W-1:0]  Dest,
    output logic [1:0]        count,
    output logic              skid_valid,
    output logic              skid_WB_en,
    output logic [REG_W-1:0]  skid_Dest
);

    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] val_rm;
        logic [REG_W-1:0]  dest;
    } beat_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    beat_t  main_q, skid_q, in_beat;
    logic   main_vld, skid_vld;
    logic   in_fire, out_fire;
    logic   load_main_in, load_main_skid, load_skid_in;

    assign in_beat = '{wb_en:      WB_en_in,
                       mem_r_en:   MEM_R_EN_in,
                       mem_w_en:   MEM_W_EN_in,
                       alu_result: ALU_Result_in,
                       val_rm:     val_Rm_in,
                       dest:       Dest_in};

    // Valid bits are decoded straight from the state register.
    assign main_vld = (state_q != S_EMPTY);
    assign skid_vld = (state_q == S_FULL);

    assign in_ready  = !skid_vld;
    assign out_valid = main_vld;
    assign count     = {1'b0, main_vld} + {1'b0, skid_vld};

    // A beat offered during flush is dropped, so it never counts as accepted.
    assign in_fire  = in_valid && in_ready && !flush;
    assign out_fire = out_valid && out_ready;

    // Enables are masked by the valid bits so a consumed beat cannot re-trigger a memory access.
    assign WB_en      = main_q.wb_en    && main_vld;
    assign MEM_R_EN   = main_q.mem_r_en && main_vld;
    assign MEM_W_EN   = main_q.mem_w_en && main_vld;
    assign ALU_result = main_q.alu_result;
    assign val_Rm     = main_q.val_rm;
    assign Dest       = main_q.dest;

    assign skid_valid = skid_vld;
    assign skid_WB_en = skid_q.wb_en && skid_vld;
    assign skid_Dest  = skid_q.dest;

    // Next-state and entry-load decode; flush overrides every handshake.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_d      = S_ONE;
                        load_main_in = 1'b1;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_d      = S_FULL;
                        load_skid_in = 1'b1;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        state_d        = S_ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // State and entry registers; reset clears everything, otherwise data holds unless reloaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_q <= in_beat;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid_in) begin
                skid_q <= in_beat;
            end
        end
    end

endmodule
